// File: rtl/store_buffer.sv
// Posted-write store buffer: a circular FIFO of {addr, data} entries drained in order
// into the backing memory, with youngest-match forwarding onto combinational loads.
module store_buffer #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int DW    = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     MemWrite_i,
   input  logic                     MemRead_i,
   input  logic [AW-1:0]            addr_i,
   input  logic [DW-1:0]            data_i,
   output logic [DW-1:0]            data_o,
   output logic                     stall_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic [AW-1:0]            mem_raddr_o,
   input  logic [DW-1:0]            mem_rdata_i,
   output logic                     mem_wvalid_o,
   output logic [AW-1:0]            mem_waddr_o,
   output logic [DW-1:0]            mem_wdata_o,
   input  logic                     mem_wready_i
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0] addr_q [DEPTH];
   logic [DW-1:0] data_q [DEPTH];

   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [CW-1:0] count;

   logic full;
   logic empty;
   logic enq;
   logic deq;
   logic [DW-1:0] fwd_data;
   logic [PW-1:0] idx;

   // MemRead_i only qualifies use of data_o upstream; the buffer itself ignores it.
   logic unused_read;
   assign unused_read = MemRead_i;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

   // A full buffer that drains on this edge frees a slot for the incoming store.
   assign stall_o      = MemWrite_i & full & ~mem_wready_i;
   assign mem_wvalid_o = ~empty & ~rst_i;
   assign mem_waddr_o  = addr_q[head];
   assign mem_wdata_o  = data_q[head];
   assign mem_raddr_o  = addr_i;

   assign enq = MemWrite_i & ~stall_o & ~rst_i;
   assign deq = mem_wvalid_o & mem_wready_i;

   // Walk oldest to youngest so the last match (nearest tail-1) wins.
   always_comb begin
      fwd_data = mem_rdata_i;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PW'(i);
         if ((CW'(i) < count) && (addr_q[idx][AW-1:2] == addr_i[AW-1:2])) begin
            fwd_data = data_q[idx];
         end
      end
   end

   assign data_o  = fwd_data;
   assign empty_o = empty;
   assign count_o = count;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (enq) tail <= tail + PW'(1);
         if (deq) head <= head + PW'(1);
         count <= count + CW'(enq) - CW'(deq);
      end
   end

   // Entry storage carries no reset; validity is tracked solely by head/count.
   always_ff @(posedge clk_i) begin
      if (enq) begin
         addr_q[tail] <= addr_i;
         data_q[tail] <= data_i;
      end
   end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: a queue-based model predicts loads, stalls and
// occupancy; a separate monitor checks every accepted backing-memory write in order.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;

   logic            clk_i = 1'b0;
   logic            rst_i = 1'b1;
   logic            MemWrite_i = 1'b0;
   logic            MemRead_i = 1'b0;
   logic [AW-1:0]   addr_i = '0;
   logic [DW-1:0]   data_i = '0;
   logic [DW-1:0]   data_o;
   logic            stall_o;
   logic            empty_o;
   logic [$clog2(DEPTH):0] count_o;
   logic [AW-1:0]   mem_raddr_o;
   logic [DW-1:0]   mem_rdata_i;
   logic            mem_wvalid_o;
   logic [AW-1:0]   mem_waddr_o;
   logic [DW-1:0]   mem_wdata_o;
   logic            mem_wready_i = 1'b0;

   int errors = 0;
   int checks = 0;

   ent_t mq[$];       // model of buffered stores, oldest first
   ent_t exp_wr[$];   // scoreboard of writes the backing memory must receive

   // Backing memory read port: a fixed address-derived pattern.
   function automatic logic [DW-1:0] mem_pat(input logic [AW-1:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign mem_rdata_i = mem_pat(mem_raddr_o);

   always #5 clk_i = ~clk_i;

   store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .MemWrite_i(MemWrite_i), .MemRead_i(MemRead_i),
      .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o),
      .empty_o(empty_o), .count_o(count_o), .mem_raddr_o(mem_raddr_o),
      .mem_rdata_i(mem_rdata_i), .mem_wvalid_o(mem_wvalid_o), .mem_waddr_o(mem_waddr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wready_i(mem_wready_i)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] exp_load(input logic [AW-1:0] a);
      for (int i = mq.size() - 1; i >= 0; i--)
         if (mq[i].a[AW-1:2] == a[AW-1:2]) return mq[i].d;
      return mem_pat(a);
   endfunction

   // Monitor: every accepted write must be the oldest outstanding expected store.
   always @(negedge clk_i) begin
      if (mem_wvalid_o && mem_wready_i) begin
         if (exp_wr.size() == 0) begin
            chk("unexpected_write", {32'h0, mem_waddr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            ent_t e;
            e = exp_wr.pop_front();
            chk("write_addr", {32'h0, mem_waddr_o}, {32'h0, e.a});
            chk("write_data", {32'h0, mem_wdata_o}, {32'h0, e.d});
         end
      end
   end

   // One clock of stimulus; checks combinational outputs mid-cycle, then advances the model.
   task automatic cycle(input bit we, input bit re, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input bit rdy, input bit rst, output bit acc);
      bit exp_stall, deq, enq;
      @(posedge clk_i);
      #1;
      rst_i = rst; MemWrite_i = we; MemRead_i = re; addr_i = a; data_i = d;
      mem_wready_i = rdy;
      @(negedge clk_i);
      acc = 1'b0;
      if (rst) begin
         mq.delete();
         exp_wr.delete();
      end else begin
         exp_stall = we && (mq.size() == DEPTH) && !rdy;
         chk("stall", {63'h0, stall_o}, {63'h0, exp_stall});
         chk("load_data", {32'h0, data_o}, {32'h0, exp_load(a)});
         chk("count", 64'(count_o), 64'(mq.size()));
         chk("empty", {63'h0, empty_o}, {63'h0, mq.size() == 0});
         chk("wvalid", {63'h0, mem_wvalid_o}, {63'h0, mq.size() != 0});
         deq = (mq.size() != 0) && rdy;
         enq = we && !exp_stall;
         if (deq) void'(mq.pop_front());
         if (enq) begin
            mq.push_back('{a: a, d: d});
            exp_wr.push_back('{a: a, d: d});
         end
         acc = enq;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int tries;
      logic [AW-1:0] a;
      // Reset then idle load
      cycle(0, 0, 32'h0, 32'h0, 0, 1, acc);
      cycle(0, 0, 32'h0, 32'h0, 0, 1, acc);
      cycle(0, 1, 32'h10, 32'h0, 0, 0, acc);

      // Single store, forwarded load, then drain
      cycle(1, 0, 32'h20, 32'hAAAA_0001, 0, 0, acc);
      cycle(0, 1, 32'h20, 32'h0, 0, 0, acc);
      cycle(0, 1, 32'h20, 32'h0, 1, 0, acc);
      cycle(0, 1, 32'h20, 32'h0, 1, 0, acc);

      // Youngest match wins; neighbour word falls through to memory
      cycle(1, 0, 32'h40, 32'h1, 0, 0, acc);
      cycle(1, 0, 32'h40, 32'h2, 0, 0, acc);
      cycle(0, 1, 32'h40, 32'h0, 0, 0, acc);
      cycle(0, 1, 32'h44, 32'h0, 0, 0, acc);
      repeat (3) cycle(0, 0, 32'h0, 32'h0, 1, 0, acc);

      // Fill, stall on the extra store, then accept it while draining
      for (int i = 0; i < DEPTH; i++)
         cycle(1, 0, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), 0, 0, acc);
      cycle(1, 0, 32'h200, 32'hCAFE_0005, 0, 0, acc);
      chk("full_store_rejected", {63'h0, acc}, 64'h0);
      cycle(1, 0, 32'h200, 32'hCAFE_0005, 1, 0, acc);
      chk("full_store_accepted", {63'h0, acc}, 64'h1);
      cycle(0, 1, 32'h200, 32'h0, 0, 0, acc);
      repeat (DEPTH + 2) cycle(0, 0, 32'h0, 32'h0, 1, 0, acc);

      // Ten stores with random ready; retry while stalled
      for (int i = 0; i < 10; i++) begin
         tries = 0;
         acc = 1'b0;
         while (!acc && tries < 50) begin
            cycle(1, 0, 32'h300 + 32'(4 * i), $urandom, 1'($urandom_range(0, 1)), 0, acc);
            tries++;
         end
         chk("ten_store_accept", {63'h0, acc}, 64'h1);
      end
      tries = 0;
      while (mq.size() != 0 && tries < 100) begin
         cycle(0, 0, 32'h0, 32'h0, 1'($urandom_range(0, 1)), 0, acc);
         tries++;
      end
      cycle(0, 0, 32'h0, 32'h0, 0, 0, acc);

      // Reset with stores pending discards them
      for (int i = 0; i < 3; i++)
         cycle(1, 0, 32'h500 + 32'(4 * i), 32'hD000_0000 + 32'(i), 0, 0, acc);
      cycle(1, 0, 32'h600, 32'hDEAD_BEEF, 1, 1, acc);
      repeat (3) cycle(0, 1, 32'h500, 32'h0, 1, 0, acc);

      // Random mixed traffic over a small address window to exercise forwarding
      for (int n = 0; n < 300; n++) begin
         a = 32'h0 + 32'(4 * $urandom_range(0, 7));
         cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
               1'($urandom_range(0, 2) != 0), 0, acc);
      end
      tries = 0;
      while (mq.size() != 0 && tries < 100) begin
         cycle(0, 0, 32'h0, 32'h0, 1, 0, acc);
         tries++;
      end
      cycle(0, 0, 32'h0, 32'h0, 1, 0, acc);
      chk("scoreboard_drained", 64'(exp_wr.size()), 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
